polar_clip_mul_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined 16x16 signed multiplier (latency MUL_LAT, clock-enable stall) among NUM_REQ requesters in the polar-clip datapath. Each requester presents an operand pair with valid/ready. The block grants at most one pair per cycle, tags it with the requester index, and tracks the tag alongside the multiplier pipeline. It returns results on a single valid/ready result port and stalls the whole multiplier through its `ce` whenever the result port is back-pressured.

---
 rtl/polar_clip_mul_arbiter.sv | 101 ++++++++++
 tb/tb_polar_clip_mul_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_clip_mul_arbiter.sv
// Round-robin share of one pipelined signed multiplier among NUM_REQ requesters, tag tracks owner.
// Latency MUL_LAT ce cycles operand-to-result; a blocked result port freezes everything via mul_ce.
module polar_clip_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic                  mul_ce,
    output logic [15:0]           mul_din0,
    output logic [15:0]           mul_din1,
    input  logic [15:0]           mul_dout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ID_W-1:0]       res_id,
    output logic [15:0]           res_data,
    output logic                  busy
);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    tag_t            tag_q [MUL_LAT];
    logic [ID_W-1:0] last_grant;
    logic            stall;
    logic            pick_vld;
    logic [ID_W-1:0] pick_idx;
    logic [ID_W:0]   cand_sum;
    logic            grant;

    assign stall     = tag_q[MUL_LAT-1].vld & ~res_ready;
    assign mul_ce    = ~stall;
    assign res_valid = tag_q[MUL_LAT-1].vld;
    assign res_id    = tag_q[MUL_LAT-1].id;
    assign res_data  = mul_dout;
    assign grant     = pick_vld & mul_ce;

    // Search starts one past the last winner and wraps at NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand_sum = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_sum = {1'b0, last_grant} + (ID_W+1)'(off);
            if (cand_sum >= NUM_REQ_W) begin
                cand_sum = cand_sum - NUM_REQ_W;
            end
            if (!pick_vld && req_valid[cand_sum[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && (pick_idx == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                mul_din0     = req_a[16*i +: 16];
                mul_din1     = req_b[16*i +: 16];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            busy = busy | tag_q[i].vld;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= ID_W'(NUM_REQ-1);
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else if (mul_ce) begin
            tag_q[0] <= {grant, pick_idx};
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (grant) begin
                last_grant <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_polar_clip_mul_arbiter.sv
// Bench for polar_clip_mul_arbiter: external multiplier model, queue-based reference, directed scenarios.
module tb_polar_clip_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 3;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic                  mul_ce;
    logic [15:0]           mul_din0;
    logic [15:0]           mul_din1;
    logic [15:0]           mul_dout;
    logic                  res_valid;
    logic                  res_ready;
    logic [ID_W-1:0]       res_id;
    logic [15:0]           res_data;
    logic                  busy;

    always #5 clk = ~clk;

    polar_clip_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    function automatic logic [15:0] mul16(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return p[15:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Multiplier with no reset, output held while ce is low.
    logic [15:0] mstage [MUL_LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            mstage[0] <= mul16(mul_din0, mul_din1);
            for (int i = 1; i < MUL_LAT; i++) mstage[i] <= mstage[i-1];
        end
    end
    assign mul_dout = mstage[MUL_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: ops in grant order, each aging one step per enabled cycle.
    typedef struct {
        int          id;
        logic [15:0] prod;
        int          age;
    } op_t;
    op_t q[$];
    int  m_last = NUM_REQ - 1;

    typedef struct {
        int          id;
        int          cyc;
        logic [15:0] data;
    } ev_t;
    ev_t gl[$];
    ev_t rl[$];

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (last + k) % NUM_REQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit model_rv();
        return (q.size() > 0) && (q[0].age == MUL_LAT);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_last = NUM_REQ - 1;
        end else begin : upd
            bit  rv;
            bit  ce;
            int  g;
            op_t t;
            rv = model_rv();
            ce = !(rv && !res_ready);
            if (ce) begin
                g = rr_pick(req_valid, m_last);
                if (rv) void'(q.pop_front());
                for (int i = 0; i < q.size(); i++) begin
                    t = q[i];
                    t.age++;
                    q[i] = t;
                end
                if (g >= 0) begin
                    t.id   = g;
                    t.prod = mul16(req_a[16*g +: 16], req_b[16*g +: 16]);
                    t.age  = 1;
                    q.push_back(t);
                    m_last = g;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit                 rv;
        bit                 ce;
        int                 g;
        logic [NUM_REQ-1:0] er;
        logic [15:0]        e0;
        logic [15:0]        e1;
        ev_t                ev;
        rv = model_rv();
        ce = !(rv && !res_ready);
        g  = ce ? rr_pick(req_valid, m_last) : -1;
        er = '0;
        e0 = '0;
        e1 = '0;
        if (g >= 0) begin
            er[g] = 1'b1;
            e0    = req_a[16*g +: 16];
            e1    = req_b[16*g +: 16];
        end
        check("req_ready", req_ready, er);
        check("mul_ce", mul_ce, ce);
        check("mul_din0", mul_din0, e0);
        check("mul_din1", mul_din1, e1);
        check("res_valid", res_valid, rv);
        check("busy", busy, q.size() > 0);
        if (rv) begin
            check("res_id", res_id, q[0].id);
            check("res_data", res_data, q[0].prod);
        end
        if (reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    ev.id = i; ev.cyc = cyc; ev.data = '0;
                    gl.push_back(ev);
                end
            end
            if (res_valid && res_ready) begin
                ev.id = res_id; ev.cyc = cyc; ev.data = res_data;
                rl.push_back(ev);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_valid[i]     = 1'b1;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((busy || res_valid) && n < budget) begin
            tick();
            n++;
        end
        check("drain_idle", busy, 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_res_valid"}, res_valid, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_req_ready"}, req_ready, 0);
        check({nm, "_mul_ce"}, mul_ce, 1);
        check({nm, "_din0"}, mul_din0, 0);
        check({nm, "_din1"}, mul_din1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g0;
        int          r0;
        int          n;
        logic [ID_W-1:0] hid;
        logic [15:0] hd;
        int          exp_ids [5];
        logic [15:0] exp_d [5];
        int          bad_sparse;

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Fairness: all four hold valid, pointer starts at requester 0.
        g0 = gl.size(); r0 = rl.size();
        set_req(0, 16'h0002, 16'h0005);
        set_req(1, 16'hFFFC, 16'h0006);
        set_req(2, 16'h0064, 16'hFF9C);
        set_req(3, 16'h0007, 16'h0007);
        repeat (5) tick();
        req_valid = '0;
        drain(20);
        exp_ids = '{0, 1, 2, 3, 0};
        exp_d   = '{16'h000A, 16'hFFE8, 16'hD8F0, 16'h0031, 16'h000A};
        check("fair_gnt_cnt", gl.size() - g0, 5);
        check("fair_res_cnt", rl.size() - r0, 5);
        for (int k = 0; k < 5; k++) begin
            if (g0 + k < gl.size()) begin
                check("fair_gnt_id", gl[g0+k].id, exp_ids[k]);
                check("fair_gnt_cyc", gl[g0+k].cyc - gl[g0].cyc, k);
            end
            if (r0 + k < rl.size() && g0 + k < gl.size()) begin
                check("fair_res_id", rl[r0+k].id, exp_ids[k]);
                check("fair_res_data", rl[r0+k].data, exp_d[k]);
                check("fair_latency", rl[r0+k].cyc - gl[g0+k].cyc, 3);
            end
        end

        // Single requester: 3 * -7.
        g0 = gl.size(); r0 = rl.size();
        set_req(0, 16'h0003, 16'hFFF9);
        #1;
        check("single_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        check("single_busy", busy, 1);
        drain(20);
        check("single_cnt", rl.size() - r0, 1);
        if (rl.size() > r0 && gl.size() > g0) begin
            check("single_id", rl[r0].id, 0);
            check("single_data", rl[r0].data, 16'hFFEB);
            check("single_latency", rl[r0].cyc - gl[g0].cyc, 3);
        end

        // Wrap-around products.
        r0 = rl.size();
        set_req(1, 16'h012C, 16'h012C);
        tick();
        req_valid = '0;
        set_req(2, 16'h8000, 16'hFFFF);
        tick();
        req_valid = '0;
        drain(20);
        check("wrap_cnt", rl.size() - r0, 2);
        if (rl.size() > r0 + 1) begin
            check("wrap_id0", rl[r0].id, 1);
            check("wrap_data0", rl[r0].data, 16'h5F90);
            check("wrap_id1", rl[r0+1].id, 2);
            check("wrap_data1", rl[r0+1].data, 16'h8000);
        end

        // Back-pressure for five cycles with the first result pending.
        g0 = gl.size(); r0 = rl.size();
        set_req(0, 16'h0011, 16'h0003);
        set_req(1, 16'hFF00, 16'h0002);
        set_req(2, 16'h1234, 16'h0010);
        set_req(3, 16'h7FFF, 16'h7FFF);
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_res_valid", res_valid, 1);
        res_ready = 1'b0;
        #1;
        hid = res_id;
        hd  = res_data;
        for (int k = 0; k < 5; k++) begin
            check("bp_ce", mul_ce, 0);
            check("bp_ready", req_ready, 0);
            check("bp_id_hold", res_id, hid);
            check("bp_data_hold", res_data, hd);
            tick();
        end
        res_ready = 1'b1;
        req_valid = '0;
        drain(40);
        check("bp_drain_cnt", rl.size() - r0, gl.size() - g0);
        for (int k = 0; k < rl.size() - r0 && g0 + k < gl.size(); k++) begin
            check("bp_order", rl[r0+k].id, gl[g0+k].id);
        end

        // Reset with three operations in flight.
        set_req(0, 16'h0005, 16'h0005);
        set_req(1, 16'h0006, 16'h0006);
        set_req(2, 16'h0007, 16'h0007);
        repeat (3) tick();
        reset_n   = 1'b0;
        req_valid = '0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) tick();
        reset_n = 1'b1;
        g0 = gl.size(); r0 = rl.size();
        set_req(0, 16'h0009, 16'hFFFE);
        set_req(2, 16'h0004, 16'h0004);
        #1;
        check("post_rst_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        drain(20);
        check("post_rst_cnt", rl.size() - r0, 1);
        if (rl.size() > r0 && gl.size() > g0) begin
            check("post_rst_id", rl[r0].id, 0);
            check("post_rst_data", rl[r0].data, 16'hFFEE);
            check("post_rst_latency", rl[r0].cyc - gl[g0].cyc, 3);
        end

        // Sparse random traffic on requesters 1 and 3.
        g0 = gl.size();
        for (int c = 0; c < 10000; c++) begin
            req_valid    = '0;
            req_valid[1] = 1'($urandom_range(0, 1));
            req_valid[3] = 1'($urandom_range(0, 1));
            req_a        = {$urandom, $urandom};
            req_b        = {$urandom, $urandom};
            res_ready    = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        drain(50);
        bad_sparse = 0;
        for (int k = g0; k < gl.size(); k++) begin
            if (gl[k].id == 0 || gl[k].id == 2) bad_sparse++;
        end
        check("sparse_idle_grants", bad_sparse, 0);
        check("sparse_some_grants", (gl.size() - g0) > 1000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
